chan_scan_ctrl: RTL and testbench
=================================

# chan_scan_ctrl

Round-robin channel scan controller that produces the 2-bit select feeding the 2-to-4 one-hot decoder. It steps through the four channels, skips channels cleared in a live enable mask, and holds each select for a programmable dwell time. Registered outputs give the downstream decoder a glitch-free select with a qualifying valid.

## Interface
- DWELL_W, 8, width of the dwell count; a channel is held for dwell+1 cycles.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled request to begin scanning; acted on only in IDLE.
- stop  in  1  abort the scan; highest priority after reset.
- mask  in  4  per-channel enable; bit i enables channel i; sampled at every selection point.
- dwell  in  DWELL_W  hold length; sampled when a channel is entered.
- sel  out  2  current channel index to the decoder; registered.
- sel_vld  out  1  sel is active; registered.
- busy  out  1  FSM is not in IDLE.
- wrap  out  1  one-cycle pulse in the first cycle of a selection whose index is ≤ the previous index.
- err  out  1  one-cycle pulse when start is seen in IDLE with mask == 0.
- done  out  1  one-cycle pulse at the end of a one-shot pass; tied 0 unless the macro is defined.

## Operation
- Reset values: state IDLE; sel=0, sel_vld=0, busy=0, wrap=0, err=0, done=0; dwell counter 0.
- States: IDLE and SCAN.
- IDLE, start=1, stop=0, mask≠0:
  - go to SCAN.
  - sel = lowest set bit of mask.
  - load the counter with dwell; sel_vld=1 and busy=1.
  - no wrap pulse.
- IDLE, start=1, stop=0, mask=0: stay in IDLE and pulse err.
- IDLE, start=1 and stop=1: stay in IDLE, no err.
- SCAN, stop=1: go to IDLE next cycle. sel_vld=0 and busy=0. sel keeps its last value. stop beats an advance in the same cycle.
- SCAN, counter≠0: decrement the counter; sel is held.
- SCAN, counter=0, selection point:
  - next = first set mask bit strictly after sel, searching (sel+1)..3 then 0..sel.
  - load next into sel and reload the counter from the current dwell.
  - pulse wrap if next ≤ old sel, which includes a single enabled channel re-selecting itself.
- Selection point with mask=0: go to IDLE, sel_vld=0, sel held, no err.
- start in SCAN is ignored. mask changes take effect only at the next selection point. dwell changes take effect only at the next channel entry.
- Index arithmetic is modulo 4. The counter is unsigned DWELL_W bits, with no underflow beyond 0.

## Timing
- Every output is registered and changes one cycle after its causing input is sampled.
- start sampled at edge k gives sel/sel_vld valid after edge k. Each channel is held exactly dwell+1 cycles.
- The advance has zero bubble: sel_vld stays 1 across channel changes.
- The stop latency is one cycle.
- rst_n assertion clears all outputs immediately, without waiting for clk. Deassertion takes effect at the next edge; the design is expected to synchronise the deassertion externally.
- A full pass over N enabled channels takes N·(dwell+1) cycles.

## Configuration
- CHAN_SCAN_ONESHOT_EN defined:
  - a selection point that would set wrap instead goes to IDLE.
  - sel_vld=0, done pulses one cycle, and wrap never asserts.
  - stop still aborts with no done pulse.
- Not defined: scanning is continuous, done is constant 0, and wrap behaves as in Operation.

## Structure
- Package chan_scan_pkg holds:
  - NCH=4 and SEL_W=2.
  - the state enum typedef (IDLE, SCAN).
- Sub-module chan_scan_next is a combinational finder:
  - inputs mask[3:0] and cur[1:0].
  - outputs next[1:0], wrapped, and any.
  - used for both the initial pick and each advance; the initial pick uses cur=3, so the search starts at channel 0.
- The top level holds the FSM, the dwell counter and the output registers.

## Test plan
- Reset, then mask=1111, dwell=2, start for 1 cycle: sel goes 0,1,2,3,0…, 3 cycles each; sel_vld=1 throughout; wrap pulses only in the first cycle of the second sel=0 (cycle 13 after start).
- mask=1010, dwell=0: sel alternates 1,3,1,3 every cycle; wrap pulses on every return to 1. mask changed to 1000 mid-run: sel stays 3 with wrap every cycle.
- start with mask=0000: err pulses 1 cycle; busy and sel_vld stay 0. start and stop together in IDLE: no activity, no err.
- stop during the second dwell cycle of channel 2: sel_vld=0 and busy=0 next cycle, sel holds 2. A restart with mask=0100 resumes at sel=2.
- rst_n low mid-dwell, between clock edges: all outputs 0 at once. After release plus start, the scan begins from the lowest enabled channel.
- Build with CHAN_SCAN_ONESHOT_EN, mask=0110, dwell=1: sel=1 for 2 cycles, sel=2 for 2 cycles, then sel_vld=0 with a done pulse in that same cycle and no wrap pulse.

Source files
------------

// File: rtl/chan_scan_pkg.sv
// Shared constants and state type for the channel scan controller.
package chan_scan_pkg;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;
endpackage

// File: rtl/chan_scan_if.sv
// Control/status bundle between a scan requester and chan_scan_ctrl.
interface chan_scan_if #(parameter int DWELL_W = 8);
    import chan_scan_pkg::*;

    logic               start;
    logic               stop;
    logic [NCH-1:0]     mask;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic               sel_vld;
    logic               busy;
    logic               wrap;
    logic               err;
    logic               done;

    modport master (output start, stop, mask, dwell,
                    input  sel, sel_vld, busy, wrap, err, done);
    modport slave  (input  start, stop, mask, dwell,
                    output sel, sel_vld, busy, wrap, err, done);
endinterface

// File: rtl/chan_scan_next.sv
// Combinational round-robin finder: first enabled channel strictly after cur,
// wrapping through cur itself. cur=NCH-1 makes the search start at channel 0.
module chan_scan_next
    import chan_scan_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] next,
    output logic             wrapped,
    output logic             any
);
    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        next  = cur;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
        any     = |mask;
        wrapped = any && (next <= cur);
    end
endmodule

// File: rtl/chan_scan_ctrl.sv
// Round-robin channel scan FSM with per-channel dwell and registered outputs.
// Define CHAN_SCAN_ONESHOT_EN to stop after one pass with a done pulse.
module chan_scan_ctrl
    import chan_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    chan_scan_if.slave bus
);
    scan_state_e        state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               vld_q, vld_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic [SEL_W-1:0]   find_cur;
    logic [SEL_W-1:0]   find_next;
    logic               find_wrapped;
    logic               find_any;

    // From IDLE search from the top index so channel 0 is tried first.
    assign find_cur = (state_q == IDLE) ? SEL_W'(NCH - 1) : sel_q;

    chan_scan_next u_next (
        .mask    (bus.mask),
        .cur     (find_cur),
        .next    (find_next),
        .wrapped (find_wrapped),
        .any     (find_any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (find_any) begin
                        state_d = SCAN;
                        sel_d   = find_next;
                        cnt_d   = bus.dwell;
                        vld_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!find_any) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end else begin
`ifdef CHAN_SCAN_ONESHOT_EN
                    if (find_wrapped) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sel_d = find_next;
                        cnt_d = bus.dwell;
                    end
`else
                    sel_d  = find_next;
                    cnt_d  = bus.dwell;
                    wrap_d = find_wrapped;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.sel_vld = vld_q;
    assign bus.busy    = (state_q == SCAN);
    assign bus.wrap    = wrap_q;
    assign bus.err     = err_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_chan_scan_ctrl.sv
// Directed, table-driven bench for chan_scan_ctrl (continuous or one-shot build).
module tb_chan_scan_ctrl;
    logic clk;
    logic rst_n;

    chan_scan_if #(.DWELL_W(8)) bus ();

    chan_scan_ctrl #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic [3:0] mask;
        logic [7:0] dwell;
        logic [1:0] sel;
        logic       vld;
        logic       busy;
        logic       wrap;
        logic       err;
        logic       done;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic st, input logic sp, input logic [3:0] m,
                       input logic [7:0] dw, input logic [1:0] s,
                       input logic v, input logic b, input logic w,
                       input logic e, input logic d);
        vec_t x;
        x.start = st; x.stop = sp; x.mask = m; x.dwell = dw;
        x.sel = s; x.vld = v; x.busy = b; x.wrap = w; x.err = e; x.done = d;
        tbl.push_back(x);
    endtask

    // Outputs packed as {sel, sel_vld, busy, wrap, err, done}.
    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {bus.sel, bus.sel_vld, bus.busy, bus.wrap, bus.err, bus.done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got sel/vld/busy/wrap/err/done=%b required=%b", name, got, exp);
        end
    endtask

    task automatic drive_step(input logic st, input logic sp, input logic [3:0] m,
                              input logic [7:0] dw);
        bus.start = st; bus.stop = sp; bus.mask = m; bus.dwell = dw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mask = 4'h0; bus.dwell = 8'd0;
        #23;
        check("reset", 7'b00_00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef CHAN_SCAN_ONESHOT_EN
        // mask=1111 dwell=2: 3 cycles per channel, wrap on the return to 0.
        add(1, 0, 4'hF, 8'd2, 2'd0, 1, 1, 0, 0, 0);
        for (int j = 1; j <= 14; j++)
            add(0, 0, 4'hF, 8'd2, 2'((j / 3) % 4), 1, 1, (j == 12), 0, 0);
        add(0, 1, 4'hF, 8'd2, 2'd0, 0, 0, 0, 0, 0);
        // mask=1010 dwell=0: alternate 1/3, then mask=1000 sticks on 3.
        add(1, 0, 4'hA, 8'd0, 2'd1, 1, 1, 0, 0, 0);
        add(0, 0, 4'hA, 8'd0, 2'd3, 1, 1, 0, 0, 0);
        add(0, 0, 4'hA, 8'd0, 2'd1, 1, 1, 1, 0, 0);
        add(0, 0, 4'hA, 8'd0, 2'd3, 1, 1, 0, 0, 0);
        add(0, 0, 4'hA, 8'd0, 2'd1, 1, 1, 1, 0, 0);
        add(0, 0, 4'h8, 8'd0, 2'd3, 1, 1, 0, 0, 0);
        add(0, 0, 4'h8, 8'd0, 2'd3, 1, 1, 1, 0, 0);
        add(0, 0, 4'h8, 8'd0, 2'd3, 1, 1, 1, 0, 0);
        add(0, 1, 4'h8, 8'd0, 2'd3, 0, 0, 0, 0, 0);
`endif
        // Empty mask start pulses err; start with stop does nothing.
        add(1, 0, 4'h0, 8'd2, tbl.size() == 0 ? 2'd0 : 2'd3, 0, 0, 0, 1, 0);
        add(0, 0, 4'h0, 8'd2, tbl.size() == 1 ? 2'd0 : 2'd3, 0, 0, 0, 0, 0);
        add(1, 1, 4'hF, 8'd2, tbl.size() == 2 ? 2'd0 : 2'd3, 0, 0, 0, 0, 0);
        // Stop in the second dwell cycle of channel 2, then resume on mask=0100.
        add(1, 0, 4'hF, 8'd2, 2'd0, 1, 1, 0, 0, 0);
        for (int j = 1; j <= 7; j++)
            add(0, 0, 4'hF, 8'd2, 2'(j / 3), 1, 1, 0, 0, 0);
        add(0, 1, 4'hF, 8'd2, 2'd2, 0, 0, 0, 0, 0);
        add(1, 0, 4'h4, 8'd2, 2'd2, 1, 1, 0, 0, 0);
        add(0, 1, 4'h4, 8'd2, 2'd2, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive_step(tbl[i].start, tbl[i].stop, tbl[i].mask, tbl[i].dwell);
            check($sformatf("vec%0d", i),
                  {tbl[i].sel, tbl[i].vld, tbl[i].busy, tbl[i].wrap, tbl[i].err, tbl[i].done});
        end

        // Asynchronous reset mid-dwell, then restart from the lowest enabled channel.
        drive_step(1, 0, 4'hF, 8'd2);
        check("pre_rst_start", 7'b00_11000);
        drive_step(0, 0, 4'hF, 8'd2);
        drive_step(0, 0, 4'hF, 8'd2);
        drive_step(0, 0, 4'hF, 8'd2);
        check("pre_rst_ch1", 7'b01_11000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 7'b00_00000);
        @(negedge clk);
        rst_n = 1'b1;
        drive_step(1, 0, 4'h6, 8'd1);
        check("post_rst_start", 7'b01_11000);

`ifdef CHAN_SCAN_ONESHOT_EN
        drive_step(0, 0, 4'h6, 8'd1);
        check("os_ch1_b", 7'b01_11000);
        drive_step(0, 0, 4'h6, 8'd1);
        check("os_ch2_a", 7'b10_11000);
        drive_step(0, 0, 4'h6, 8'd1);
        check("os_ch2_b", 7'b10_11000);
        drive_step(0, 0, 4'h6, 8'd1);
        check("os_done", 7'b10_00001);
        drive_step(0, 0, 4'h6, 8'd1);
        check("os_idle", 7'b10_00000);
`else
        drive_step(0, 0, 4'h6, 8'd1);
        check("ct_ch1_b", 7'b01_11000);
        drive_step(0, 0, 4'h6, 8'd1);
        check("ct_ch2_a", 7'b10_11000);
        drive_step(0, 0, 4'h6, 8'd1);
        drive_step(0, 0, 4'h6, 8'd1);
        check("ct_wrap1", 7'b01_11100);
        drive_step(0, 1, 4'h6, 8'd1);
        check("ct_stop", 7'b01_00000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
